capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences one capture buffer instance through a full acquisition: arm, wait for trigger, collect a programmed number of post-trigger samples, stop, read out, clear.
- Drives the buffer's start/circular/stop/reset/read-address controls.
- Streams stored samples oldest-first over a valid/ready interface, unwrapping the circular buffer.
- Sits between the capture buffer and the host readout logic.

Parameters:
CAPTURE_WIDTH  32   sample width; must match the buffer.
CAPTURE_SIZE   128  buffer depth; power of two, >=2; must match the buffer.

Ports:
clk                 in   1              clock
reset               in   1              synchronous, active-high reset
arm                 in   1              pulse; starts a sequence when idle
abort               in   1              pulse; cancels the sequence, discards data
trigger             in   1              trigger event
post_count          in   32             post-trigger samples; sampled on accepted arm
capture_data_valid  in   1              same strobe that feeds the buffer
busy                out  1              high whenever state != IDLE
done                out  1              one-cycle pulse when a readout completes
cap_start           out  1              to buffer capture_start
cap_circular        out  1              to buffer capture_circular
cap_stop            out  1              to buffer capture_stop
cap_reset           out  1              to buffer capture_reset
cap_rd_addr         out  32             to buffer capture_rd_addr
cap_rd_data         in   CAPTURE_WIDTH  from buffer; valid 1 clk after address
cap_amount          in   32             from buffer capture_amount
cap_pos             in   32             from buffer capture_pos
out_data            out  CAPTURE_WIDTH  readout sample
out_valid           out  1              readout valid
out_ready           in   1              readout ready
out_last            out  1              qualifies the final beat

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- All outputs are registered or decoded from state. No combinational input-to-output paths.
- States: IDLE, START, ARMED, POST, STOP, ABORT_STOP, SETTLE, RD_ADDR, RD_DATA, OUT, CLEAR.
- cap_start: 1 only in START. cap_stop: 1 only in STOP and ABORT_STOP. cap_reset: 1 only in CLEAR.
- cap_circular: 1 in START, ARMED, POST; 0 otherwise.
- done: 1 in CLEAR only when CLEAR was entered from a completed readout or an empty capture.
- IDLE: arm=1 -> latch post_count, go to START. arm in any other state is ignored.
- START: go to ARMED after 1 cycle.
- ARMED:
  - trigger=1 and post_count=0 -> STOP.
  - trigger=1 otherwise -> POST, with cnt = capture_data_valid (the trigger-cycle sample counts).
  - If cnt reaches post_count in that same cycle -> STOP directly.
- POST: each capture_data_valid cycle does cnt+1. When the incremented cnt equals post_count, go to STOP the next cycle. Exactly post_count post-trigger samples are written; a valid arriving in the STOP cycle is not stored.
- STOP: go to SETTLE.
- SETTLE:
  - Latch amt = cap_amount.
  - Latch start = ((cap_pos mod SIZE) + SIZE - amt) mod SIZE; mod is the low log2(SIZE) bits.
  - Set idx = 0.
  - amt=0 -> CLEAR (done pulses, no beats). Otherwise -> RD_ADDR.
- RD_ADDR: cap_rd_addr = (start+idx) mod SIZE, zero-extended, registered on entry and held through RD_DATA. Go to RD_DATA.
- RD_DATA:
  - Register cap_rd_data into out_data.
  - out_last = (idx == amt-1).
  - Go to OUT.
- OUT:
  - out_valid=1, and out_data/out_last are held stable until out_ready.
  - On out_valid & out_ready: if out_last -> CLEAR; else idx+1 -> RD_ADDR.
  - Throughput: 1 beat per 3 cycles minimum.
- CLEAR: 1 cycle, then IDLE. The buffer returns to IDLE with address and amount cleared.
- abort has priority over trigger, count and handshake:
  - In START, ARMED or POST -> ABORT_STOP, then CLEAR. The buffer is stopped before it is reset.
  - In STOP, SETTLE, RD_ADDR, RD_DATA or OUT -> CLEAR next cycle. out_valid drops without a handshake.
  - Ignored in IDLE and CLEAR.
  - done is not pulsed on an abort path.
- post_count > SIZE is legal; the oldest samples, including the trigger sample, are overwritten and amt saturates at SIZE.
- reset mid-sequence returns to IDLE immediately; the buffer is reset by the same reset.
- idx and cnt are 32 bits and never wrap in legal use.

Test Plan:
- SIZE=8, arm, 3 valid samples (values 1..3), trigger with valid (value 4), post_count=2, then value 5 -> cap_stop one cycle after sample 5; stream 1,2,3,4,5 with out_last on 5; done pulses once; cap_reset follows.
- SIZE=8, 12 samples 1..12 pre-trigger, trigger with post_count=0 -> amt=8, start=4; stream 5..12 oldest-first, 8 beats.
- post_count=0, trigger before any valid sample -> amt=0, no out_valid, done pulse, back in IDLE within 4 cycles.
- out_ready held low 10 cycles on beat 2 -> out_data/out_last stable, no address advance; sequence completes correctly once ready rises.
- abort while in POST -> cap_stop then cap_reset on consecutive cycles, no done, no beats; a following arm/trigger sequence reads only new data.
- arm pulsed during OUT and trigger pulsed during IDLE -> both ignored; synchronous reset asserted during OUT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Drives one capture buffer through arm, trigger wait,
//               post-trigger collection, stop, oldest-first readout over a
//               valid/ready stream, and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int CAPTURE_WIDTH = 32,
    parameter int CAPTURE_SIZE  = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trigger,
    input  logic [31:0]              post_count,
    input  logic                     capture_data_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     cap_start,
    output logic                     cap_circular,
    output logic                     cap_stop,
    output logic                     cap_reset,
    output logic [31:0]              cap_rd_addr,
    input  logic [CAPTURE_WIDTH-1:0] cap_rd_data,
    input  logic [31:0]              cap_amount,
    input  logic [31:0]              cap_pos,
    output logic [CAPTURE_WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    // Buffer index width; only the low bits of position/amount address memory.
    localparam int c_addr_w = $clog2(CAPTURE_SIZE);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_START      = 4'd1,
        S_ARMED      = 4'd2,
        S_POST       = 4'd3,
        S_STOP       = 4'd4,
        S_ABORT_STOP = 4'd5,
        S_SETTLE     = 4'd6,
        S_RD_ADDR    = 4'd7,
        S_RD_DATA    = 4'd8,
        S_OUT        = 4'd9,
        S_CLEAR      = 4'd10
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [31:0]              r_post;      // post-trigger target latched at arm
    logic [31:0]              r_cnt;       // post-trigger samples written so far
    logic [31:0]              r_amt;       // samples held by the buffer
    logic [31:0]              r_idx;       // readout beat index
    logic [c_addr_w-1:0]      r_start;     // physical slot of the oldest sample
    logic [31:0]              r_rd_addr;
    logic [CAPTURE_WIDTH-1:0] r_out_data;
    logic                     r_out_last;
    logic                     r_done_ok;   // CLEAR was reached by a clean finish

    logic [31:0]              w_cnt_inc;
    logic [31:0]              w_idx_inc;
    logic [c_addr_w-1:0]      w_start;
    logic [c_addr_w-1:0]      w_addr_low;
    logic                     w_done_ok;
    logic                     w_unused_pos;

    // Oldest slot = write position minus amount, modulo the buffer depth.
    assign w_start   = cap_pos[c_addr_w-1:0] - cap_amount[c_addr_w-1:0];
    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_idx_inc = r_idx + 32'd1;

    // Position above the buffer depth carries no address information.
    assign w_unused_pos = ^cap_pos[31:c_addr_w];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection and state-decoded outputs; abort outranks all else.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_ok    = 1'b0;
        w_addr_low   = r_start + w_idx_inc[c_addr_w-1:0];
        busy         = (r_state != S_IDLE);
        cap_start    = (r_state == S_START);
        cap_circular = (r_state == S_START) || (r_state == S_ARMED) ||
                       (r_state == S_POST);
        cap_stop     = (r_state == S_STOP) || (r_state == S_ABORT_STOP);
        cap_reset    = (r_state == S_CLEAR);
        out_valid    = (r_state == S_OUT);
        done         = (r_state == S_CLEAR) && r_done_ok;

        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = abort ? S_ABORT_STOP : S_ARMED;
            end
            S_ARMED: begin
                if (abort) begin
                    w_state_nxt = S_ABORT_STOP;
                end else if (trigger) begin
                    // The trigger-cycle sample already counts toward the target.
                    if ((r_post == 32'd0) ||
                        ({31'd0, capture_data_valid} == r_post)) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_POST;
                    end
                end
            end
            S_POST: begin
                if (abort) begin
                    w_state_nxt = S_ABORT_STOP;
                end else if (capture_data_valid && (w_cnt_inc == r_post)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_state_nxt = abort ? S_CLEAR : S_SETTLE;
            end
            S_ABORT_STOP: begin
                // Stop the buffer before it is reset.
                w_state_nxt = S_CLEAR;
            end
            S_SETTLE: begin
                w_addr_low = w_start;
                if (abort) begin
                    w_state_nxt = S_CLEAR;
                end else if (cap_amount == 32'd0) begin
                    w_state_nxt = S_CLEAR;
                    w_done_ok   = 1'b1;
                end else begin
                    w_state_nxt = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                w_state_nxt = abort ? S_CLEAR : S_RD_DATA;
            end
            S_RD_DATA: begin
                w_state_nxt = abort ? S_CLEAR : S_OUT;
            end
            S_OUT: begin
                if (abort) begin
                    w_state_nxt = S_CLEAR;
                end else if (out_ready) begin
                    if (r_out_last) begin
                        w_state_nxt = S_CLEAR;
                        w_done_ok   = 1'b1;
                    end else begin
                        w_state_nxt = S_RD_ADDR;
                    end
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, readout address and the registered output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_post     <= 32'd0;
            r_cnt      <= 32'd0;
            r_amt      <= 32'd0;
            r_idx      <= 32'd0;
            r_start    <= '0;
            r_rd_addr  <= 32'd0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_done_ok  <= 1'b0;
        end else begin
            r_done_ok <= w_done_ok;

            // Address is registered as the FSM enters RD_ADDR, held through RD_DATA.
            if (w_state_nxt == S_RD_ADDR) begin
                r_rd_addr <= {{(32-c_addr_w){1'b0}}, w_addr_low};
            end

            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_post <= post_count;
                    end
                end
                S_ARMED: begin
                    if (!abort && trigger) begin
                        r_cnt <= {31'd0, capture_data_valid};
                    end
                end
                S_POST: begin
                    if (!abort && capture_data_valid) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    r_amt   <= cap_amount;
                    r_start <= w_start;
                    r_idx   <= 32'd0;
                end
                S_RD_DATA: begin
                    r_out_data <= cap_rd_data;
                    r_out_last <= (r_idx == (r_amt - 32'd1));
                end
                S_OUT: begin
                    if (!abort && out_ready && !r_out_last) begin
                        r_idx <= w_idx_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cap_rd_addr = r_rd_addr;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Self-checking bench for capture_sequencer with a behavioural
//               capture buffer and a sample-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             arm;
    logic             abort;
    logic             trigger;
    logic [31:0]      post_count;
    logic             capture_data_valid;
    logic             busy;
    logic             done;
    logic             cap_start;
    logic             cap_circular;
    logic             cap_stop;
    logic             cap_reset;
    logic [31:0]      cap_rd_addr;
    logic [WIDTH-1:0] cap_rd_data;
    logic [31:0]      cap_amount;
    logic [31:0]      cap_pos;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    logic [WIDTH-1:0] wdata;

    int checks = 0;
    int errors = 0;
    int next_val;
    bit rand_data;
    logic [31:0] written[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    capture_sequencer #(
        .CAPTURE_WIDTH (WIDTH),
        .CAPTURE_SIZE  (SIZE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .arm                (arm),
        .abort              (abort),
        .trigger            (trigger),
        .post_count         (post_count),
        .capture_data_valid (capture_data_valid),
        .busy               (busy),
        .done               (done),
        .cap_start          (cap_start),
        .cap_circular       (cap_circular),
        .cap_stop           (cap_stop),
        .cap_reset          (cap_reset),
        .cap_rd_addr        (cap_rd_addr),
        .cap_rd_data        (cap_rd_data),
        .cap_amount         (cap_amount),
        .cap_pos            (cap_pos),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last)
    );

    // Behavioural capture buffer: circular store while capturing, saturating amount.
    logic [WIDTH-1:0] bmem [SIZE];
    logic [31:0]      bpos;
    logic [31:0]      bamt;
    logic             bcap;

    always @(posedge clk) begin
        if (reset || cap_reset) begin
            bpos <= 32'd0;
            bamt <= 32'd0;
            bcap <= 1'b0;
        end else if (cap_start) begin
            bcap <= 1'b1;
        end else if (cap_stop) begin
            bcap <= 1'b0;
        end else if (bcap && capture_data_valid) begin
            bmem[bpos[AW-1:0]] <= wdata;
            bpos <= bpos + 32'd1;
            if (bamt < SIZE) bamt <= bamt + 32'd1;
        end
        cap_rd_data <= bmem[cap_rd_addr[AW-1:0]];
    end

    assign cap_pos    = bpos;
    assign cap_amount = bamt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_cap_start"}, cap_start, 1'b0);
        chk1({tag, "_cap_circular"}, cap_circular, 1'b0);
        chk1({tag, "_cap_stop"}, cap_stop, 1'b0);
        chk1({tag, "_cap_reset"}, cap_reset, 1'b0);
        chk32({tag, "_cap_rd_addr"}, cap_rd_addr, 32'd0);
        chk32({tag, "_out_data"}, out_data, 32'd0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_out_last"}, out_last, 1'b0);
    endtask

    task automatic drive_sample(input bit v, input bit keep);
        capture_data_valid = v;
        if (rand_data) begin
            wdata = $urandom;
        end else begin
            wdata = 32'(next_val);
            if (v) next_val++;
        end
        if (v && keep) written.push_back(wdata);
    endtask

    // Arm, then land in ARMED; post_count is scrambled to prove it was latched.
    task automatic start_seq(input int p);
        arm = 1'b1;
        post_count = 32'(p);
        tick();
        arm = 1'b0;
        post_count = $urandom;
        chk1("start_cap_start", cap_start, 1'b1);
        chk1("start_cap_circular", cap_circular, 1'b1);
        chk1("start_busy", busy, 1'b1);
        tick();
        chk1("armed_cap_start", cap_start, 1'b0);
        chk1("armed_cap_circular", cap_circular, 1'b1);
    endtask

    // Full acquisition; returns with the DUT in SETTLE.
    task automatic capture(input int pre_n, input int p, input bit tv, input bit dense);
        int post;
        bit v;
        written.delete();
        start_seq(p);
        for (int i = 0; i < pre_n; i++) begin
            v = dense ? 1'b1 : 1'($urandom_range(0, 1));
            drive_sample(v, 1'b1);
            tick();
        end
        trigger = 1'b1;
        drive_sample(tv, 1'b1);
        tick();
        trigger = 1'b0;
        post = (p > 0 && tv) ? 1 : 0;
        for (int g = 0; g < 1000 && post < p; g++) begin
            chk1("post_cap_stop", cap_stop, 1'b0);
            v = dense ? 1'b1 : 1'($urandom_range(0, 1));
            drive_sample(v, 1'b1);
            tick();
            if (v) post++;
        end
        chk1("stop_cap_stop", cap_stop, 1'b1);
        chk1("stop_cap_circular", cap_circular, 1'b0);
        // A sample in the stop cycle must not reach the buffer.
        capture_data_valid = 1'b1;
        wdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
        tick();
        capture_data_valid = 1'b0;
    endtask

    // Readout from SETTLE; expectation is the newest min(n, SIZE) samples, oldest first.
    task automatic readout(input int stall_beat, input bit rand_ready, input bit arm_during);
        int n;
        int amt;
        int beats;
        int stall_left;
        bit got_done;
        bit pend;
        bit armed_once;
        bit rdy;
        logic [31:0] pd;
        logic [31:0] pa;
        logic pl;
        n = written.size();
        amt = (n > SIZE) ? SIZE : n;
        exp_q.delete();
        for (int i = n - amt; i < n; i++) exp_q.push_back(written[i]);
        beats = 0;
        stall_left = 10;
        got_done = 1'b0;
        pend = 1'b0;
        armed_once = 1'b0;
        pd = '0;
        pa = '0;
        pl = 1'b0;
        chk1("settle_out_valid", out_valid, 1'b0);
        chk1("settle_cap_circular", cap_circular, 1'b0);
        tick();
        if (amt > 0) chk32("first_rd_addr", cap_rd_addr, 32'((n - amt) % SIZE));
        for (int budget = 0; budget < 400; budget++) begin
            if (pend) begin
                chk1("stall_out_valid", out_valid, 1'b1);
                chk32("stall_out_data", out_data, pd);
                chk1("stall_out_last", out_last, pl);
                chk32("stall_rd_addr", cap_rd_addr, pa);
            end
            if (done) begin
                got_done = 1'b1;
                chk32("done_beats", 32'(beats), 32'(amt));
                chk1("done_cap_reset", cap_reset, 1'b1);
                break;
            end
            if (out_valid && beats == stall_beat && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (arm_during && out_valid && !armed_once) begin
                arm = 1'b1;
                armed_once = 1'b1;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk1("extra_beat_valid", out_valid, 1'b0);
                end else begin
                    chk32("beat_data", out_data, exp_q.pop_front());
                    chk1("beat_last", out_last, exp_q.size() == 0);
                end
                beats++;
                pend = 1'b0;
            end else if (out_valid) begin
                pend = 1'b1;
                pd = out_data;
                pl = out_last;
                pa = cap_rd_addr;
            end else begin
                pend = 1'b0;
            end
            tick();
            arm = 1'b0;
        end
        out_ready = 1'b0;
        chk1("readout_done", got_done, 1'b1);
        tick();
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_done", done, 1'b0);
    endtask

    // From SETTLE to the first OUT cycle with ready held low.
    task automatic goto_out();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        chk1("goto_out_valid", out_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        trigger = 1'b0;
        post_count = 32'd0;
        capture_data_valid = 1'b0;
        out_ready = 1'b0;
        wdata = '0;
        rand_data = 1'b0;
        next_val = 1;
        tick();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Trigger while idle is ignored.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk1("idle_trig_busy", busy, 1'b0);
        chk1("idle_trig_cap_start", cap_start, 1'b0);

        // Three pre-trigger, trigger sample, one more post sample.
        next_val = 1;
        capture(3, 2, 1'b1, 1'b1);
        readout(-1, 1'b0, 1'b0);

        // Wrapped buffer: twelve samples into eight slots, trigger without data.
        next_val = 1;
        capture(12, 0, 1'b0, 1'b1);
        readout(-1, 1'b0, 1'b0);

        // Empty capture: done with no beats.
        capture(0, 0, 1'b0, 1'b1);
        readout(-1, 1'b0, 1'b0);

        // Ten-cycle stall on the second beat, arm pulsed during readout.
        next_val = 100;
        capture(2, 3, 1'b1, 1'b1);
        readout(1, 1'b0, 1'b1);

        // Abort while collecting post-trigger samples.
        next_val = 200;
        written.delete();
        start_seq(5);
        drive_sample(1'b1, 1'b1);
        tick();
        trigger = 1'b1;
        drive_sample(1'b1, 1'b1);
        tick();
        trigger = 1'b0;
        drive_sample(1'b1, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        capture_data_valid = 1'b0;
        chk1("abort_post_cap_stop", cap_stop, 1'b1);
        chk1("abort_post_cap_reset", cap_reset, 1'b0);
        chk1("abort_post_out_valid", out_valid, 1'b0);
        tick();
        chk1("abort_clear_cap_reset", cap_reset, 1'b1);
        chk1("abort_clear_cap_stop", cap_stop, 1'b0);
        chk1("abort_clear_done", done, 1'b0);
        tick();
        chk1("abort_idle_busy", busy, 1'b0);
        next_val = 500;
        capture(1, 1, 1'b1, 1'b1);
        readout(-1, 1'b1, 1'b0);

        // Abort during OUT drops valid without a handshake.
        capture(4, 1, 1'b0, 1'b1);
        goto_out();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_out_cap_reset", cap_reset, 1'b1);
        chk1("abort_out_done", done, 1'b0);
        tick();
        chk1("abort_out_idle", busy, 1'b0);

        // Randomised acquisitions, including post_count above the depth.
        rand_data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            capture(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    1'($urandom_range(0, 1)), 1'b0);
            readout(int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end
        rand_data = 1'b0;

        // Synchronous reset during OUT.
        next_val = 900;
        capture(3, 1, 1'b1, 1'b1);
        goto_out();
        reset = 1'b1;
        tick();
        check_all_zero("reset_out");
        reset = 1'b0;
        tick();
        next_val = 950;
        capture(2, 1, 1'b1, 1'b1);
        readout(-1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
